// File: rtl/dds_dac_formatter.sv
// rtl/dds_dac_formatter.sv - round, saturate and buffer modulator samples as offset-binary DAC codes
module dds_dac_formatter #(
    parameter int IN_W  = 257,
    parameter int OUT_W = 14,
    parameter int SHIFT = 120,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    input  logic             clear_stats,
    output logic             sat_flag,
    output logic [15:0]      sat_count,
    output logic [15:0]      drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Sign-extend by one bit so adding the rounding constant never overflows.
    logic signed [IN_W:0] wide;
    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;

    assign wide = {in_data[IN_W-1], in_data};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
            assign rounded = wide + HALF;
        end else begin : g_no_round
            assign rounded = wide;
        end
    endgenerate

    assign shifted = rounded >>> SHIFT;

    // The value fits in OUT_W signed bits iff every bit from the OUT_W-1 position up is a copy of the sign.
    logic [IN_W-OUT_W+1:0] upper;
    logic                  fits;
    logic                  clip;
    logic [OUT_W-1:0]      sat_val;
    logic [OUT_W-1:0]      code;

    assign upper = shifted[IN_W:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);
    assign clip  = ~fits;

    // Clip to the most negative / most positive code, then flip the MSB for offset binary.
    always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (!fits) begin
            sat_val = shifted[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    assign code = {~sat_val[OUT_W-1], sat_val[OUT_W-2:0]};

    // Handshake: stage 1 counts as occupied FIFO space so the FIFO can never overflow.
    logic            s1_valid;
    logic [OUT_W-1:0] s1_code;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            accept;
    logic            drop;
    logic            push;
    logic            pop;

    assign in_ready = (count + CW'(s1_valid)) < DEPTH_C;
    assign accept   = in_valid & in_ready;
    assign drop     = in_valid & ~in_ready;
    assign push     = s1_valid;
    assign pop      = out_valid & out_ready;

    // Stage-1 register: holds the freshly formatted code for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_code <= code;
            end
        end
    end

    logic [OUT_W-1:0] mem [DEPTH];

    // Storage array; contents need no reset because count gates their use.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= s1_code;
        end
    end

    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    left;
    logic [OUT_W-1:0] head_next;

    // Post-edge occupancy and head; a push into an otherwise empty FIFO becomes the head directly.
    always_comb begin
        rd_next   = rd_ptr + AW'(pop);
        left      = count - CW'(pop);
        cnt_next  = left + CW'(push);
        head_next = mem[rd_next];
        if (left == '0) begin
            head_next = s1_code;
        end
    end

    // Pointer, occupancy and registered show-ahead output; out_data keeps the last code when empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_next;
            count     <= cnt_next;
            out_valid <= (cnt_next != '0);
            if (cnt_next != '0) begin
                out_data <= head_next;
            end
        end
    end

    logic [15:0] sat_base;
    logic [15:0] drop_base;

    assign sat_base  = clear_stats ? 16'h0000 : sat_count;
    assign drop_base = clear_stats ? 16'h0000 : drop_count;

    // Bring-up statistics; an event on the clearing edge lands on top of the cleared value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag   <= 1'b0;
            sat_count  <= '0;
            drop_count <= '0;
        end else begin
            sat_flag <= (sat_flag & ~clear_stats) | (accept & clip);
            if (accept && clip && sat_base != 16'hFFFF) begin
                sat_count <= sat_base + 16'd1;
            end else begin
                sat_count <= sat_base;
            end
            if (drop && drop_base != 16'hFFFF) begin
                drop_count <= drop_base + 16'd1;
            end else begin
                drop_count <= drop_base;
            end
        end
    end

endmodule

// File: tb/tb_dds_dac_formatter.sv
// tb/tb_dds_dac_formatter.sv - randomized and directed bench for dds_dac_formatter
module tb_dds_dac_formatter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        clear_stats;
    logic        sat_flag;
    logic [15:0] sat_count;
    logic [15:0] drop_count;

    dds_dac_formatter #(
        .IN_W (32),
        .OUT_W(8),
        .SHIFT(4),
        .DEPTH(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .clear_stats(clear_stats),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples accepted but not yet consumed, with the edge they were accepted on.
    int     q_code[$];
    int     q_edge[$];
    int     edge_n   = 0;
    int     exp_last = 0;
    int     m_sat    = 0;
    int     m_drop   = 0;
    bit     m_flag   = 0;
    int     emitted  = 0;

    // Round half toward +inf by floor((x + 8) / 16), clip to signed 8 bits, bias by 128.
    function automatic void ref_code(input logic [31:0] d, output int code, output bit clip);
        longint v;
        longint r;
        v = longint'($signed(d)) + 8;
        if (v >= 0) r = v / 16;
        else        r = -((-v + 15) / 16);
        clip = 1'b0;
        if (r > 127)  begin r = 127;  clip = 1'b1; end
        if (r < -128) begin r = -128; clip = 1'b1; end
        code = int'(r) + 128;
    endfunction

    task automatic model_reset();
        q_code.delete();
        q_edge.delete();
        exp_last = 0;
        m_sat    = 0;
        m_drop   = 0;
        m_flag   = 0;
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model across the edge.
    task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit clr);
        bit exp_ready;
        bit exp_valid;
        bit acc;
        bit pop;
        bit clip;
        int code;
        exp_ready = (q_code.size() < 4);
        exp_valid = (q_code.size() > 0) && (q_edge[0] <= edge_n - 1);
        if (exp_valid) exp_last = q_code[0];
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, exp_valid);
        chk("out_data", out_data, exp_last);
        chk("sat_flag", sat_flag, m_flag);
        chk("sat_count", sat_count, m_sat);
        chk("drop_count", drop_count, m_drop);
        in_valid    = iv;
        in_data     = d;
        out_ready   = ordy;
        clear_stats = clr;
        ref_code(d, code, clip);
        acc = iv && exp_ready;
        pop = exp_valid && ordy;
        @(posedge clock);
        edge_n++;
        if (pop) begin
            void'(q_code.pop_front());
            void'(q_edge.pop_front());
            emitted++;
        end
        if (acc) begin
            q_code.push_back(code);
            q_edge.push_back(edge_n);
        end
        if (clr) begin
            m_sat  = 0;
            m_drop = 0;
            m_flag = 0;
        end
        if (acc && clip) begin
            m_flag = 1;
            if (m_sat < 65535) m_sat++;
        end
        if (iv && !exp_ready && m_drop < 65535) m_drop++;
        #1;
        in_valid    = 1'b0;
        clear_stats = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, ordy, 1'b0);
    endtask

    logic [31:0] rnd_data;
    int          mode;

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_count", sat_count, 0);
        reset_n = 1'b1;
        model_reset();

        // Rounding
        step(1, 32'd256, 1, 0);
        step(1, 32'd24, 1, 0);
        step(1, 32'd23, 1, 0);
        step(1, -32'sd8, 1, 0);
        step(1, -32'sd24, 1, 0);
        idle(4, 1);
        chk("round_sat_flag", sat_flag, 0);
        chk("round_last", out_data, 8'h7F);

        // Saturation
        step(1, 32'd4000, 1, 0);
        step(1, -32'sd5000, 1, 0);
        step(1, 32'h7FFFFFFF, 1, 0);
        idle(4, 1);
        chk("sat_total", sat_count, 3);
        chk("sat_flag_set", sat_flag, 1);
        chk("sat_last", out_data, 8'hFF);

        // Backpressure
        step(0, 32'd0, 1, 1);
        for (int i = 1; i <= 8; i++) step(1, 32'(16 * i), 0, 0);
        chk("bp_drops", drop_count, 4);
        chk("bp_ready", in_ready, 0);
        emitted = 0;
        idle(6, 1);
        chk("bp_emitted", emitted, 4);
        chk("bp_last", out_data, 8'h84);

        // Streaming
        emitted = 0;
        for (int i = 0; i < 100; i++) step(1, 32'(i * 16), 1, 0);
        idle(4, 1);
        chk("stream_emitted", emitted, 100);
        chk("stream_drops", drop_count, 4);

        // Reset mid-operation with three samples buffered
        step(1, 32'd4000, 0, 0);
        step(1, 32'd48, 0, 0);
        step(1, 32'd64, 0, 0);
        idle(2, 0);
        chk("pre_rst_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_sat_count", sat_count, 0);
        chk("async_drop_count", drop_count, 0);
        chk("async_sat_flag", sat_flag, 0);
        chk("async_out_data", out_data, 0);
        #1 reset_n = 1'b1;
        model_reset();
        step(1, 32'd256, 1, 0);
        step(0, 32'd0, 1, 0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_code", out_data, 8'h90);
        idle(2, 1);

        // clear_stats coinciding with a clipped accept
        step(1, 32'd4000, 1, 1);
        chk("clr_clip_count", sat_count, 1);
        chk("clr_clip_flag", sat_flag, 1);
        step(0, 32'd0, 1, 1);
        chk("clr_count", sat_count, 0);
        chk("clr_flag", sat_flag, 0);
        idle(3, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) rnd_data = $urandom();
            else           rnd_data = 32'($signed(int'($urandom_range(0, 6000)) - 3000));
            step(bit'($urandom_range(0, 3) != 0), rnd_data,
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 40) == 0));
        end
        idle(8, 1);
        chk("final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
